threshold_sequencer: RTL
========================

// Module: threshold_sequencer
// PURPOSE
//  Top-level sequencer for the histogram/median threshold datapath. Runs pass 1 (clear
//  counters, stream every pixel address into the histogram counters), triggers the
//  median priority-encoder search and latches its result, then runs pass 2 (re-read
//  every pixel, assert write enable for the thresholded 0/255 output).
//  Replaces the free-running done/enable/we glue with one explicit FSM.
// PARAMETERS
//  NPIX     4096  pixels per frame; addresses 0..NPIX-1
//  AW       12    address width, 2**AW >= NPIX
//  RD_LAT   1     pixel memory read latency in cycles (1..4)
//  TIMEOUT  1023  max SRCH cycles before error abort
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  start         in   1   begin frame; sampled only in IDLE
//  abort         in   1   synchronous abort; highest priority
//  rd_addr       out  AW  pixel memory read address
//  rd_en         out  1   pixel memory read strobe
//  hist_clr      out  1   clear all 256 counters (1 cycle)
//  hist_en       out  1   counter increment enable (rd_en delayed RD_LAT, pass 1 only)
//  search_start  out  1   1-cycle pulse to priority encoder
//  search_done   in   1   encoder result valid
//  thresh_in     in   8   encoder median bin
//  thresh_q      out  8   latched threshold for the 8-bit comparator
//  we            out  1   output write enable (rd_en delayed RD_LAT, pass 2 only)
//  wr_addr       out  AW  output write address (rd_addr delayed RD_LAT)
//  busy          out  1   high in every state except IDLE
//  finished      out  1   1-cycle pulse at end of frame
//  err           out  1   sticky search-timeout flag; cleared by next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, incl. thresh_q, rd_addr, wr_addr, err.
//  States: IDLE -> CLR -> HIST -> HDRN -> SRCH -> THR -> TDRN -> DONE -> IDLE.
//  IDLE: start=1 at edge k -> CLR; err cleared at the same edge. start ignored elsewhere.
//  CLR: exactly 1 cycle, hist_clr=1, no rd_en.
//  HIST: NPIX consecutive cycles with rd_en=1, rd_addr=0,1,..,NPIX-1, no gaps.
//   After last address -> HDRN.
//  HDRN: RD_LAT cycles so the final hist_en issues. hist_en = rd_en delayed RD_LAT via
//   valid shift register tagged with pass id; exactly NPIX hist_en pulses per frame.
//  SRCH: search_start=1 on the first SRCH cycle only. search_done sampled every SRCH
//   cycle, including the first. On search_done: thresh_q<=thresh_in, -> THR.
//   TIMEOUT cycles without done: err<=1, -> IDLE, no pass 2.
//  THR: as HIST (NPIX reads from addr 0). we/wr_addr = rd_en/rd_addr delayed RD_LAT.
//  TDRN: RD_LAT cycles draining the last we. Then DONE: finished=1 one cycle -> IDLE.
//  thresh_q held stable from latch until next frame's search_done, and through IDLE.
//  rd_addr counter: AW bits; terminal test is addr==NPIX-1, never relies on wrap.
//   Returns to 0 on leaving HIST/THR.
//  abort=1 in any state: next state IDLE. Delay-line valid bits flushed, so no hist_en
//   or we issues after the abort edge. No finished pulse. err, thresh_q unchanged.
//   abort and start together in IDLE: stay IDLE.
//  rst_n low mid-frame: immediate return to reset values; no partial writes after.
//  Per frame: exactly NPIX hist_en pulses and NPIX we pulses, unless aborted/timed out.
// TESTING
//  NPIX=16,RD_LAT=1; start@k, done 3 cycles into SRCH -> hist_clr@k+1; 16 hist_en
//   k+3..k+18; search_start@k+19; 16 we with wr_addr 0..15; one finished pulse.
//  search_done high on first SRCH cycle, thresh_in=8'd97 -> thresh_q=97 at next edge;
//   THR entered at once.
//  search_done never asserted, TIMEOUT=20 -> err=1 after 20 SRCH cycles; IDLE; no we.
//   Next start clears err.
//  abort on 5th THR cycle with RD_LAT=3 -> IDLE next cycle; zero we after abort edge;
//   no finished.
//  rst_n low in HIST mid-address -> all outputs 0 asynchronously. Fresh start after
//   release runs a full clean frame.
//  start pulsed during HIST/SRCH/THR ignored; start held high through DONE -> new frame
//   begins from IDLE the cycle after finished.

Source files
------------

// File: rtl/threshold_sequencer.sv
// Frame sequencer for the histogram/median threshold datapath: pass 1 fills the
// histogram, a median search latches the threshold, and pass 2 writes the thresholded pixels.
module threshold_sequencer #(
    parameter int unsigned NPIX    = 4096,
    parameter int unsigned AW      = 12,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    output logic          hist_clr,
    output logic          hist_en,
    output logic          search_start,
    input  logic          search_done,
    input  logic [7:0]    thresh_in,
    output logic [7:0]    thresh_q,
    output logic          we,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          finished,
    output logic          err
);

    localparam int unsigned MAXC = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, CLR, HIST, HDRN, SRCH, THR, TDRN, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last_addr, drain_end, srch_tmo;

    logic          rd_pass, rd_pass_nx;
    logic          rd_en_nx, hist_clr_nx, search_start_nx, busy_nx, finished_nx, err_nx;
    logic [AW-1:0] rd_addr_nx;
    logic [7:0]    thresh_nx;

    logic [RD_LAT-1:0] hv, wv;
    logic [AW-1:0]     wa [RD_LAT];

    assign last_addr = (rd_addr == AW'(NPIX - 1));
    assign drain_end = (cnt == CW'(RD_LAT - 1));
    assign srch_tmo  = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Abort overrides every transition, including start in IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CLR;
            CLR:     state_nx = HIST;
            HIST:    if (last_addr) state_nx = HDRN;
            HDRN:    if (drain_end) state_nx = SRCH;
            SRCH: begin
                if (search_done)   state_nx = THR;
                else if (srch_tmo) state_nx = IDLE;
            end
            THR:     if (last_addr) state_nx = TDRN;
            TDRN:    if (drain_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        rd_en_nx        = (state_nx == HIST) || (state_nx == THR);
        rd_pass_nx      = (state_nx == THR);
        rd_addr_nx      = '0;
        if (rd_en_nx && (state_nx == state)) rd_addr_nx = rd_addr + AW'(1);
        hist_clr_nx     = (state_nx == CLR);
        search_start_nx = (state_nx == SRCH) && (state != SRCH);
        busy_nx         = (state_nx != IDLE);
        finished_nx     = (state_nx == DONE);
        thresh_nx       = thresh_q;
        err_nx          = err;
        if (!abort) begin
            if (state == SRCH && search_done) thresh_nx = thresh_in;
            if (state == IDLE && start)
                err_nx = 1'b0;
            else if (state == SRCH && !search_done && srch_tmo)
                err_nx = 1'b1;
        end
        cnt_nx = '0;
        if ((state_nx == state) && (state == HDRN || state == SRCH || state == TDRN))
            cnt_nx = cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en        <= 1'b0;
            rd_pass      <= 1'b0;
            rd_addr      <= '0;
            hist_clr     <= 1'b0;
            search_start <= 1'b0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            thresh_q     <= '0;
            err          <= 1'b0;
        end else begin
            rd_en        <= rd_en_nx;
            rd_pass      <= rd_pass_nx;
            rd_addr      <= rd_addr_nx;
            hist_clr     <= hist_clr_nx;
            search_start <= search_start_nx;
            busy         <= busy_nx;
            finished     <= finished_nx;
            thresh_q     <= thresh_nx;
            err          <= err_nx;
        end
    end

    // Read-latency delay line; separate valid chains per pass, flushed on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv <= '0;
            wv <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) wa[i] <= '0;
        end else begin
            hv[0] <= rd_en & ~rd_pass;
            wv[0] <= rd_en & rd_pass;
            wa[0] <= rd_addr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                hv[i] <= hv[i-1];
                wv[i] <= wv[i-1];
                wa[i] <= wa[i-1];
            end
            if (abort) begin
                hv <= '0;
                wv <= '0;
            end
        end
    end

    assign hist_en = hv[RD_LAT-1];
    assign we      = wv[RD_LAT-1];
    assign wr_addr = wa[RD_LAT-1];

endmodule
